// File: rtl/viterbi_acs_pmu.sv
// Add-compare-select / path-metric unit for a K=3, rate-1/2 (7,5) Viterbi decoder.
// Define ACS_BEST_STATE_EN to add the registered best_state output.
`timescale 1ns/1ps
module viterbi_acs_pmu #(
   parameter int PM_W      = 8,
   parameter int INIT_PM   = 63,
   parameter int FRAME_LEN = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init,
   input  logic              in_valid,
   input  logic [1:0]        bm00,
   input  logic [1:0]        bm01,
   input  logic [1:0]        bm10,
   input  logic [1:0]        bm11,
   output logic              out_valid,
   output logic [3:0]        decision,
   output logic [4*PM_W-1:0] pm_out,
   output logic              frame_last
`ifdef ACS_BEST_STATE_EN
   ,
   output logic [1:0]        best_state
`endif
);

   localparam int              CNT_W    = $clog2(FRAME_LEN);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
   localparam logic [PM_W:0]   SAT_MAX  = {1'b0, {PM_W{1'b1}}};
   localparam logic [PM_W-1:0] HALF     = {1'b1, {(PM_W-1){1'b0}}};
   localparam logic [PM_W-1:0] INIT_VAL = PM_W'(INIT_PM);

   logic [3:0][PM_W-1:0] pm;
   logic [3:0][PM_W-1:0] pm_sel;
   logic [3:0][PM_W-1:0] pm_next;
   logic [3:0][1:0]      bm;
   logic [3:0]           dec_next;
   logic [CNT_W-1:0]     cnt;

   assign bm     = {bm11, bm10, bm01, bm00};
   assign pm_out = pm;

   // Sum is one bit wider so a carry out clamps instead of wrapping.
   function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] m, input logic [1:0] d);
      logic [PM_W:0] s;
      s = {1'b0, m} + {{(PM_W-1){1'b0}}, d};
      return (s > SAT_MAX) ? SAT_MAX[PM_W-1:0] : s[PM_W-1:0];
   endfunction

   always_comb begin
      logic            u, n0, all_hi;
      logic [1:0]      c_a, c_b;
      logic [PM_W-1:0] a, b;
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      pm_sel   = '0;
      pm_next  = '0;
      dec_next = '0;
      all_hi   = 1'b1;
      u = 1'b0; n0 = 1'b0; c_a = '0; c_b = '0; a = '0; b = '0;
      for (int n = 0; n < 4; n++) begin
         // Next state n = {u, n0}; predecessors {n0,0} (a) and {n0,1} (b).
         u   = 1'(n >> 1);
         n0  = 1'(n);
         c_a = {u ^ n0, u};
         c_b = {~(u ^ n0), ~u};
         a   = sat_add(pm[{n0, 1'b0}], bm[c_a]);
         b   = sat_add(pm[{n0, 1'b1}], bm[c_b]);
         dec_next[n] = (b < a);
         pm_sel[n]   = (b < a) ? b : a;
         all_hi      = all_hi & pm_sel[n][PM_W-1];
      end
      for (int n = 0; n < 4; n++) begin
         pm_next[n] = all_hi ? (pm_sel[n] - HALF) : pm_sel[n];
      end
   end

`ifdef ACS_BEST_STATE_EN
   logic [1:0] best_next;

   always_comb begin
      best_next = 2'd0;
      for (int n = 1; n < 4; n++) begin
         if (pm_next[n] < pm_next[best_next]) best_next = 2'(n);
      end
   end
`endif

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst || init) begin
         pm         <= {INIT_VAL, INIT_VAL, INIT_VAL, {PM_W{1'b0}}};
         out_valid  <= 1'b0;
         decision   <= '0;
         frame_last <= 1'b0;
         cnt        <= '0;
`ifdef ACS_BEST_STATE_EN
         best_state <= 2'd0;
`endif
      end else begin
         out_valid <= in_valid;
         if (in_valid) begin
            pm         <= pm_next;
            decision   <= dec_next;
            frame_last <= (cnt == CNT_LAST);
            cnt        <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
`ifdef ACS_BEST_STATE_EN
            best_state <= best_next;
`endif
         end
      end
   end

endmodule

// File: tb/tb_viterbi_acs_pmu.sv
// Self-checking bench for viterbi_acs_pmu: trellis-level reference model plus directed cases,
// run on a PM_W=8 instance and a PM_W=6 instance driven by the same stimulus.
`timescale 1ns/1ps
module tb_viterbi_acs_pmu;

   localparam int FRAME_LEN = 16;
   localparam int INIT_PM   = 63;

   logic        clk = 1'b0;
   logic        rst, init, in_valid;
   logic [1:0]  bm00, bm01, bm10, bm11;

   logic        ov_a, fl_a, ov_b, fl_b;
   logic [3:0]  dec_a, dec_b;
   logic [31:0] pm_a;
   logic [23:0] pm_b;
`ifdef ACS_BEST_STATE_EN
   logic [1:0]  best_a, best_b;
`endif

   int  n_checks = 0;
   int  n_fail   = 0;
   bit  chk_en   = 1'b0;

   always #5 clk = ~clk;

   viterbi_acs_pmu #(.PM_W(8), .INIT_PM(INIT_PM), .FRAME_LEN(FRAME_LEN)) dut_a (
      .clk(clk), .rst(rst), .init(init), .in_valid(in_valid),
      .bm00(bm00), .bm01(bm01), .bm10(bm10), .bm11(bm11),
      .out_valid(ov_a), .decision(dec_a), .pm_out(pm_a), .frame_last(fl_a)
`ifdef ACS_BEST_STATE_EN
      , .best_state(best_a)
`endif
   );

   viterbi_acs_pmu #(.PM_W(6), .INIT_PM(INIT_PM), .FRAME_LEN(FRAME_LEN)) dut_b (
      .clk(clk), .rst(rst), .init(init), .in_valid(in_valid),
      .bm00(bm00), .bm01(bm01), .bm10(bm10), .bm11(bm11),
      .out_valid(ov_b), .decision(dec_b), .pm_out(pm_b), .frame_last(fl_b)
`ifdef ACS_BEST_STATE_EN
      , .best_state(best_b)
`endif
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference ACS step straight from the encoder rules: walk every (state, input) edge.
   function automatic void acs_model(input int pw, input int pm[4], input int bmv[4],
                                     output int npm[4], output int dec, output int best);
      int maxv, half, cand, sel, chosen, c1, c0;
      bit first, all_hi;
      maxv = (1 << pw) - 1;
      half = 1 << (pw - 1);
      dec  = 0;
      for (int n = 0; n < 4; n++) begin
         first = 1'b1; sel = 0; chosen = 0;
         for (int p = 0; p < 4; p++) begin
            for (int u = 0; u < 2; u++) begin
               if ((2 * u + p / 2) == n) begin
                  c1   = u ^ (p / 2) ^ (p % 2);
                  c0   = u ^ (p % 2);
                  cand = pm[p] + bmv[2 * c1 + c0];
                  if (cand > maxv) cand = maxv;
                  if (first || cand < sel) begin
                     sel    = cand;
                     chosen = p % 2;
                     first  = 1'b0;
                  end
               end
            end
         end
         npm[n] = sel;
         dec    = dec | (chosen << n);
      end
      all_hi = 1'b1;
      for (int n = 0; n < 4; n++) if (npm[n] < half) all_hi = 1'b0;
      if (all_hi) for (int n = 0; n < 4; n++) npm[n] = npm[n] - half;
      best = 0;
      for (int n = 1; n < 4; n++) if (npm[n] < npm[best]) best = n;
   endfunction

   int  bmv[4];
   int  ma_pm[4], mb_pm[4], na_pm[4], nb_pm[4];
   int  ma_dec, mb_dec, na_dec, nb_dec;
   int  ma_best, mb_best, na_best, nb_best;
   int  m_cnt;
   bit  m_ov, m_fl;

   always_comb begin
      bmv[0] = int'(bm00);
      bmv[1] = int'(bm01);
      bmv[2] = int'(bm10);
      bmv[3] = int'(bm11);
      acs_model(8, ma_pm, bmv, na_pm, na_dec, na_best);
      acs_model(6, mb_pm, bmv, nb_pm, nb_dec, nb_best);
   end

   always @(posedge clk) begin
      if (rst || init) begin
         ma_pm <= '{0, INIT_PM, INIT_PM, INIT_PM};
         mb_pm <= '{0, INIT_PM, INIT_PM, INIT_PM};
         ma_dec <= 0; mb_dec <= 0; ma_best <= 0; mb_best <= 0;
         m_ov <= 1'b0; m_fl <= 1'b0; m_cnt <= 0;
      end else begin
         m_ov <= in_valid;
         if (in_valid) begin
            ma_pm <= na_pm;   mb_pm <= nb_pm;
            ma_dec <= na_dec; mb_dec <= nb_dec;
            ma_best <= na_best; mb_best <= nb_best;
            m_fl  <= (m_cnt == FRAME_LEN - 1);
            m_cnt <= (m_cnt + 1) % FRAME_LEN;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         check("model out_valid a", ov_a, m_ov);
         check("model out_valid b", ov_b, m_ov);
         check("model decision a", dec_a, ma_dec);
         check("model decision b", dec_b, mb_dec);
         check("model frame_last a", fl_a, m_fl);
         check("model frame_last b", fl_b, m_fl);
         for (int s = 0; s < 4; s++) begin
            check("model pm a", pm_a[s*8 +: 8], ma_pm[s]);
            check("model pm b", pm_b[s*6 +: 6], mb_pm[s]);
         end
`ifdef ACS_BEST_STATE_EN
         check("model best_state a", best_a, ma_best);
         check("model best_state b", best_b, mb_best);
`endif
      end
   end

   task automatic step(input logic v, input logic [1:0] b00, input logic [1:0] b01,
                       input logic [1:0] b10, input logic [1:0] b11);
      in_valid = v;
      bm00 = b00; bm01 = b01; bm10 = b10; bm11 = b11;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      init     = 1'b0;
      rst      = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step(1'b0, 2'd0, 2'd0, 2'd0, 2'd0);
   endtask

   task automatic check_pm_a(input string name, input int p0, input int p1, input int p2, input int p3);
      check(name, pm_a, {p3[7:0], p2[7:0], p1[7:0], p0[7:0]});
   endtask

   logic [31:0] snap;

   initial begin
      rst = 1'b1; init = 1'b0; in_valid = 1'b0;
      bm00 = '0; bm01 = '0; bm10 = '0; bm11 = '0;
      @(posedge clk);
      #1;
      rst    = 1'b0;
      chk_en = 1'b1;

      // Reset state
      check("reset out_valid", ov_a, 0);
      check("reset decision", dec_a, 0);
      check("reset frame_last", fl_a, 0);
      check_pm_a("reset pm", 0, 63, 63, 63);

      // T1: single symbol
      step(1'b1, 2'd0, 2'd1, 2'd1, 2'd2);
      check("t1 out_valid", ov_a, 1);
      check("t1 decision", dec_a, 0);
      check_pm_a("t1 pm", 0, 64, 2, 64);
`ifdef ACS_BEST_STATE_EN
      check("t1 best_state", best_a, 0);
`endif

      // T2: all branch metrics 2; tie at symbol 3, normalisation at symbol 64
      do_reset();
      for (int k = 1; k <= 64; k++) begin
         step(1'b1, 2'd2, 2'd2, 2'd2, 2'd2);
         if (k == 1)  check_pm_a("t2 pm sym1", 2, 65, 2, 65);
         if (k == 2)  check_pm_a("t2 pm sym2", 4, 4, 4, 4);
         if (k == 3)  check("t2 tie decision", dec_a, 0);
         if (k == 63) check_pm_a("t2 pm sym63", 126, 126, 126, 126);
         if (k == 64) check_pm_a("t2 pm sym64 normalised", 0, 0, 0, 0);
      end

      // T3: saturation on the 6-bit instance
      do_reset();
      step(1'b1, 2'd0, 2'd2, 2'd2, 2'd0);
      check("t3 pm b s1 saturated", pm_b[6 +: 6], 63);
      check("t3 decision b bit1", dec_b[1], 0);
      check("t3 pm b all", pm_b, {6'd63, 6'd0, 6'd63, 6'd0});

      // T6: steer metrics so b<a on every next state
      do_reset();
      step(1'b1, 2'd2, 2'd2, 2'd2, 2'd0);
      step(1'b1, 2'd2, 2'd2, 2'd0, 2'd2);
      check_pm_a("t6 pm setup", 4, 0, 4, 2);
      step(1'b1, 2'd0, 2'd2, 2'd2, 2'd0);
      check("t6 decision b<a", dec_a, 4'b1111);
      check_pm_a("t6 pm", 0, 4, 0, 4);

      // T4: frame boundaries over 40 back-to-back symbols, then idle hold
      do_reset();
      for (int k = 1; k <= 40; k++) begin
         step(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
         check("t4 out_valid", ov_a, 1);
         check("t4 frame_last", fl_a, (k == 16 || k == 32) ? 1 : 0);
      end
      snap = pm_a;
      for (int k = 0; k < 3; k++) begin
         step(1'b0, 2'($urandom_range(0, 3)), 2'd3, 2'd3, 2'd3);
         check("t4 idle out_valid", ov_a, 0);
         check("t4 idle pm held", pm_a, snap);
      end

      // T5: init coincident with symbol 7 drops it and restarts the frame
      do_reset();
      for (int k = 1; k <= 6; k++) step(1'b1, 2'd1, 2'd0, 2'd2, 2'd1);
      init = 1'b1;
      step(1'b1, 2'd0, 2'd0, 2'd0, 2'd0);
      check("t5 out_valid", ov_a, 0);
      check_pm_a("t5 pm", 0, 63, 63, 63);
      for (int k = 1; k <= 16; k++) begin
         step(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
         check("t5 frame_last", fl_a, (k == 16) ? 1 : 0);
      end

      // Random traffic with sporadic init/rst, checked by the model every cycle
      for (int k = 0; k < 800; k++) begin
         init = ($urandom_range(0, 59) == 0);
         rst  = ($urandom_range(0, 249) == 0);
         step(1'($urandom_range(0, 9) < 7),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
              2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      end

      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
